// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: in-order word fetches from a PC register into a DEPTH-entry prefetch FIFO.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, resp_pc;
  logic [CW-1:0] count, inflight, inflight_nxt, discard;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_dat [DEPTH];
  logic [31:0]   fifo_pc  [DEPTH];
  logic [CW:0]   occ;
  logic          redir, resp, push, pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (halt)  state_nxt = HALTED;
      HALTED:  if (!halt) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffered plus outstanding fetches never exceed DEPTH, so a response always has a free slot.
  assign occ          = {1'b0, count} + {1'b0, inflight};
  assign redir        = redirect_valid && (state != IDLE);
  assign resp         = mem_rvalid && (inflight != '0);
  assign mem_req      = (state == FETCH) && !halt && !redirect_valid && (discard == '0) && (occ < DEPTH_W);
  assign push         = resp && (discard == '0) && !redir;
  assign pop          = inst_valid && inst_ready && !redir;
  assign inflight_nxt = inflight + CW'(mem_req) - CW'(resp);

  assign mem_addr   = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? fifo_dat[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]  : 32'h0;
  assign busy       = (state != IDLE) || (inflight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_dat[i] <= 32'h0;
        fifo_pc[i]  <= 32'h0;
      end
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (redir) begin
        // Every request still outstanding after this edge belongs to the stale path.
        pc      <= redirect_pc;
        resp_pc <= redirect_pc;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        discard <= inflight_nxt + discard;
      end else begin
        if (mem_req) pc <= pc + PC_INC;
        if (resp && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          fifo_dat[wr_ptr] <= mem_rdata;
          fifo_pc[wr_ptr]  <= resp_pc;
          wr_ptr           <= wr_ptr + AW'(1);
          resp_pc          <= resp_pc + PC_INC;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (mem_req && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == FETCH) && inst_ready && !inst_valid && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed stimulus, negedge memory model and output monitor.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req, inst_valid, busy;
  logic [31:0] mem_addr, inst_data, inst_pc;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        hi_mem_req, hi_inst_valid, hi_busy;
  logic [31:0] hi_mem_addr, hi_inst_data, hi_inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, hi_perf_fetch_cnt, hi_perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Second instance exercises PC wrap from a high reset PC; it never receives responses.
  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(hi_mem_req), .mem_addr(hi_mem_addr), .mem_rvalid(1'b0), .mem_rdata(32'h0),
    .inst_valid(hi_inst_valid), .inst_ready(inst_ready), .inst_data(hi_inst_data), .inst_pc(hi_inst_pc),
    .busy(hi_busy)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(hi_perf_fetch_cnt), .perf_stall_cnt(hi_perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb_q[$];
  bit          sb_armed = 1'b0;
  int          cyc = 0;
  int          pop_log[$];
  logic [31:0] addr_log[$];
  logic [31:0] hi_log[$];
  int          req_cnt = 0;
  int          lat = 1;
  logic        pv [4] = '{default: 1'b0};
  logic [31:0] pa [4] = '{default: 32'h0};
  int          tot_s = 0, bad_s = 0, tot_m = 0, bad_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with 'lat' cycles from request to rvalid, driven away from the active edge.
  always @(negedge clk) begin
    mem_rvalid = pv[0];
    mem_rdata  = mdata(pa[0]);
    for (int i = 0; i < 3; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[3] = 1'b0;
    pa[3] = 32'h0;
    if (!rst && mem_req) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = mem_addr;
      addr_log.push_back(mem_addr);
      req_cnt++;
    end
    if (!rst && hi_mem_req) hi_log.push_back(hi_mem_addr);
  end

  // Output monitor: every accepted instruction is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      pop_log.push_back(cyc);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        tot_m++;
        if (inst_pc !== e.pc) begin
          bad_m++;
          $display("FAIL sb_inst_pc: got %h want %h", inst_pc, e.pc);
        end
        tot_m++;
        if (inst_data !== e.dat) begin
          bad_m++;
          $display("FAIL sb_inst_data (pc %h): got %h want %h", e.pc, inst_data, e.dat);
        end
      end else if (sb_armed) begin
        tot_m++;
        bad_m++;
        $display("FAIL sb_unexpected: got inst_pc %h want no delivery", inst_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_s++;
    if (act !== exp) begin
      bad_s++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] p);
    sb_q.push_back('{pc: p, dat: mdata(p)});
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
    sb_armed = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_data"},  inst_data,       32'h0);
    chk({tag, "_inst_pc"},    inst_pc,         32'h0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    int base, abase, rbase, hbase;

    // Reset state
    tick(1);
    chk_reset_outputs("rst");
    chk("rst_hi_mem_addr", hi_mem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

    // Streaming with 1-cycle memory, decode always ready
    do_reset();
    lat = 1; inst_ready = 1'b1;
    base = pop_log.size(); abase = addr_log.size();
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    sb_armed = 1'b1;
    start_pulse();
    chk("t1_first_req", 32'(mem_req), 32'd1);
    chk("t1_first_addr", mem_addr, 32'h0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_sb("t1_stream_done", 40);
    if (pop_log.size() >= base + 8) chk("t1_back_to_back", 32'(pop_log[base+7] - pop_log[base]), 32'd7);
    else chk("t1_pop_count", 32'(pop_log.size() - base), 32'd8);
    for (int i = 0; i < 3; i++) chk("t1_addr_seq", addr_log[abase+i], 32'(i * 4));

    // Decode stalled: credits fill the FIFO, then release
    do_reset();
    lat = 1; inst_ready = 1'b0;
    abase = addr_log.size(); rbase = req_cnt;
    start_pulse();
    tick(10);
    chk("t2_req_cnt", 32'(req_cnt - rbase), 32'd4);
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head_data", inst_data, mdata(32'h0));
    chk("t2_no_req", 32'(mem_req), 32'd0);
    chk("t2_pc_hold", mem_addr, 32'd16);
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    sb_armed = 1'b1;
    inst_ready = 1'b1;
    wait_sb("t2_drain", 40);
    for (int i = 0; i < 5; i++) chk("t2_addr_seq", addr_log[abase+i], 32'(i * 4));

    // Redirect with two fetches in flight, 3-cycle memory
    do_reset();
    lat = 3; inst_ready = 1'b1;
    abase = addr_log.size();
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    sb_armed = 1'b1;
    start_pulse();
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("t3_no_req_on_redirect", 32'(mem_req), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("t3_fifo_empty", 32'(inst_valid), 32'd0);
    chk("t3_new_pc", mem_addr, 32'h100);
    chk("t3_discard_blocks", 32'(mem_req), 32'd0);
    tick(1);
    chk("t3_discard_blocks2", 32'(mem_req), 32'd0);
    tick(1);
    chk("t3_refetch_req", 32'(mem_req), 32'd1);
    chk("t3_refetch_addr", mem_addr, 32'h100);
    wait_sb("t3_drain", 40);
    chk("t3_log_addr", addr_log[abase+2], 32'h100);

    // Halt with one fetch in flight, then resume and reset mid-run
    do_reset();
    lat = 1; inst_ready = 1'b1;
    abase = addr_log.size(); rbase = req_cnt;
    push_exp(32'h0); push_exp(32'h4);
    sb_armed = 1'b1;
    start_pulse();
    tick(2);
    halt = 1'b1;
    #1;
    chk("t4_halt_pc", mem_addr, 32'h8);
    chk("t4_halt_no_req", 32'(mem_req), 32'd0);
    tick(6);
    chk("t4_halt_req_cnt", 32'(req_cnt - rbase), 32'd2);
    chk("t4_halt_busy", 32'(busy), 32'd1);
    wait_sb("t4_inflight_delivered", 4);
    push_exp(32'h8); push_exp(32'hC);
    sb_armed = 1'b1;
    halt = 1'b0;
    tick(1);
    chk("t4_resume_req", 32'(mem_req), 32'd1);
    chk("t4_resume_addr", mem_addr, 32'h8);
    wait_sb("t4_resume_drain", 20);
    tick(2);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t4_midrun_rst");
    rst = 1'b0;

`ifdef FETCH_PERF_EN
    // Performance counters: 10 fetches, 3 ready-but-empty cycles with 2-cycle memory
    do_reset();
    lat = 2; inst_ready = 1'b1;
    start_pulse();
    tick(10);
    halt = 1'b1;
    tick(6);
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd10);
    chk("t6_perf_stall", perf_stall_cnt, 32'd3);
    halt = 1'b0;
`endif

    // PC wrap from RESET_PC 0xFFFF_FFF8
    do_reset();
    lat = 1; inst_ready = 1'b0;
    hbase = hi_log.size();
    start_pulse();
    tick(10);
    chk("t5_hi_req_cnt", 32'(hi_log.size() - hbase), 32'd4);
    chk("t5_hi_addr0", hi_log[hbase],   32'hFFFF_FFF8);
    chk("t5_hi_addr1", hi_log[hbase+1], 32'hFFFF_FFFC);
    chk("t5_hi_addr2", hi_log[hbase+2], 32'h0000_0000);
    chk("t5_hi_busy", 32'(hi_busy), 32'd1);
    chk("t5_hi_inst_valid", 32'(hi_inst_valid), 32'd0);
    chk("t5_hi_inst_data", hi_inst_data, 32'h0);
    chk("t5_hi_inst_pc", hi_inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("t5_hi_perf_fetch", hi_perf_fetch_cnt, 32'd4);
    chk("t5_hi_perf_stall", hi_perf_stall_cnt, 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("t5_rst_hi_addr", hi_mem_addr, 32'hFFFF_FFF8);
    chk("t5_rst_hi_busy", 32'(hi_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", tot_s + tot_m, bad_s + bad_m);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
